// File: rtl/branch_pc_unit_pkg.sv
// Shared definitions for the branch / next-PC unit of the 16-bit core.
// Holds the opcode and condition-code encodings, the run/halt state
// type and the default reset PC used by branch_pc_unit and cond_eval.
package branch_pc_unit_pkg;

    // Opcodes in instr[15:12] that this unit acts on; all others are sequential.
    localparam logic [3:0] OP_B   = 4'b1100;
    localparam logic [3:0] OP_BR  = 4'b1101;
    localparam logic [3:0] OP_PCS = 4'b1110;
    localparam logic [3:0] OP_HLT = 4'b1111;

    // Condition codes in instr[11:9].
    localparam logic [2:0] CC_NE  = 3'b000;
    localparam logic [2:0] CC_EQ  = 3'b001;
    localparam logic [2:0] CC_GT  = 3'b010;
    localparam logic [2:0] CC_LT  = 3'b011;
    localparam logic [2:0] CC_GE  = 3'b100;
    localparam logic [2:0] CC_LE  = 3'b101;
    localparam logic [2:0] CC_OV  = 3'b110;
    localparam logic [2:0] CC_UNC = 3'b111;

    localparam logic [15:0] DEFAULT_RESET_PC = 16'h0000;

    typedef enum logic {
        RUN  = 1'b0,
        HALT = 1'b1
    } state_e;

endpackage

// File: rtl/branch_pc_unit_cond_eval.sv
// Condition-code evaluator for B/BR.
// Ports:
//   ccc       : condition code from instr[11:9]
//   n, z, v   : registered negative / zero / overflow flags
//   cond_true : 1 when the selected condition holds
module cond_eval
    import branch_pc_unit_pkg::*;
(
    input  logic [2:0] ccc,
    input  logic       n,
    input  logic       z,
    input  logic       v,
    output logic       cond_true
);

    // GE is written exactly as the ISA defines it (Z or (not Z and not N)),
    // which reduces to "Z or not N".
    always_comb begin
        cond_true = 1'b0;
        unique case (ccc)
            CC_NE:   cond_true = ~z;
            CC_EQ:   cond_true = z;
            CC_GT:   cond_true = ~z & ~n;
            CC_LT:   cond_true = n;
            CC_GE:   cond_true = z | (~z & ~n);
            CC_LE:   cond_true = n | z;
            CC_OV:   cond_true = v;
            CC_UNC:  cond_true = 1'b1;
            default: cond_true = 1'b0;
        endcase
    end

endmodule

// File: rtl/cla_16bit.sv
// 16-bit adder/subtractor shared by the datapath.
// Ports:
//   a, b : operands
//   sub  : 0 = a + b, 1 = a - b (b inverted, carry-in set)
//   sum  : 16-bit result, wraps modulo 2^16 (carry-out is not exported)
module cla_16bit (
    input  logic [15:0] a,
    input  logic [15:0] b,
    input  logic        sub,
    output logic [15:0] sum
);

    // Generate/propagate form; the carry walks from bit 0 upward and the
    // final carry-out is simply dropped, giving wrap-around arithmetic.
    always_comb begin
        logic [15:0] b_x;
        logic [15:0] gen;
        logic [15:0] prop;
        logic        carry;
        b_x   = b ^ {16{sub}};
        gen   = a & b_x;
        prop  = a ^ b_x;
        carry = sub;
        sum   = '0;
        for (int i = 0; i < 16; i++) begin
            sum[i] = prop[i] ^ carry;
            carry  = gen[i] | (prop[i] & carry);
        end
    end

endmodule

// File: rtl/branch_pc_unit.sv
// Architectural PC, branch resolution and halt control for the 16-bit core.
// Ports:
//   clk, rst      : clock and synchronous active-high reset
//   instr         : current instruction ([15:12] opcode, [11:9] ccc, [8:0] imm9)
//   rs_data       : register value used as the BR target
//   stall         : holds PC, state and taken counter while high
//   N/Z/V_Flag    : registered flags from the execute stage
//   pc_out        : current PC (instruction memory address)
//   pc_plus2      : pc_out + 2, also the PCS writeback value
//   taken         : current instruction is a B/BR whose condition holds
//   halted        : machine is frozen by HLT; only rst leaves this state
//   taken_cnt     : saturating count of taken branches
module branch_pc_unit
    import branch_pc_unit_pkg::*;
#(
    parameter logic [15:0] RESET_PC = DEFAULT_RESET_PC,
    parameter int          CNT_W    = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [15:0]      instr,
    input  logic [15:0]      rs_data,
    input  logic             stall,
    input  logic             N_Flag,
    input  logic             Z_Flag,
    input  logic             V_Flag,
    output logic [15:0]      pc_out,
    output logic [15:0]      pc_plus2,
    output logic             taken,
    output logic             halted,
    output logic [CNT_W-1:0] taken_cnt
);

    logic [15:0]      pc_q, pc_d;
    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic [3:0]  opcode;
    logic        cond_true;
    logic        is_branch;
    logic [15:0] br_offset;
    logic [15:0] b_target;

    assign opcode    = instr[15:12];
    assign is_branch = (opcode == OP_B) || (opcode == OP_BR);
    assign taken     = is_branch & cond_true;

    // imm9 counts halfwords, so it is sign-extended and shifted left by one.
    assign br_offset = {{6{instr[8]}}, instr[8:0], 1'b0};

    cond_eval u_cond_eval (
        .ccc       (instr[11:9]),
        .n         (N_Flag),
        .z         (Z_Flag),
        .v         (V_Flag),
        .cond_true (cond_true)
    );

    cla_16bit u_inc_adder (
        .a   (pc_q),
        .b   (16'h0002),
        .sub (1'b0),
        .sum (pc_plus2)
    );

    // B targets are relative to the following instruction, not the B itself.
    cla_16bit u_target_adder (
        .a   (pc_plus2),
        .b   (br_offset),
        .sub (1'b0),
        .sum (b_target)
    );

    // Next-state logic: everything holds unless the machine is running and
    // not stalled. HLT keeps the PC on itself so the halt address stays visible.
    always_comb begin
        pc_d    = pc_q;
        state_d = state_q;
        cnt_d   = cnt_q;
        if (state_q == RUN && !stall) begin
            if (opcode == OP_HLT) begin
                state_d = HALT;
            end else if (taken && opcode == OP_B) begin
                pc_d = b_target;
            end else if (taken) begin
                pc_d = rs_data;
            end else begin
                pc_d = pc_plus2;
            end
            if (taken && cnt_q != {CNT_W{1'b1}}) begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    // Reset overrides stall, HLT and branches, and is the only way out of HALT.
    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q    <= RESET_PC;
            state_q <= RUN;
            cnt_q   <= '0;
        end else begin
            pc_q    <= pc_d;
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    assign pc_out    = pc_q;
    assign halted    = (state_q == HALT);
    assign taken_cnt = cnt_q;

endmodule

// File: tb/tb_branch_pc_unit.sv
// Self-checking bench for branch_pc_unit. A behavioural model tracks the
// PC as an integer, the halt condition as a flag and the taken count as an
// integer clamped at its maximum; the DUT is compared against it every cycle.
module tb_branch_pc_unit;

    localparam int CNT_W   = 8;
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    logic             clk = 1'b0;
    logic             rst;
    logic [15:0]      instr;
    logic [15:0]      rs_data;
    logic             stall;
    logic             n_flag, z_flag, v_flag;
    logic [15:0]      pc_out;
    logic [15:0]      pc_plus2;
    logic             taken;
    logic             halted;
    logic [CNT_W-1:0] taken_cnt;

    int checks = 0;
    int errors = 0;

    int modelPc;
    bit modelHalted;
    int modelCnt;

    always #5 clk = ~clk;

    branch_pc_unit #(
        .RESET_PC (16'h0000),
        .CNT_W    (CNT_W)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .instr     (instr),
        .rs_data   (rs_data),
        .stall     (stall),
        .N_Flag    (n_flag),
        .Z_Flag    (z_flag),
        .V_Flag    (v_flag),
        .pc_out    (pc_out),
        .pc_plus2  (pc_plus2),
        .taken     (taken),
        .halted    (halted),
        .taken_cnt (taken_cnt)
    );

    // Condition table as written in the ISA manual.
    function automatic bit modelCond(input logic [2:0] ccc, input bit n, input bit z, input bit v);
        case (ccc)
            3'd0: return !z;
            3'd1: return z;
            3'd2: return !z && !n;
            3'd3: return n;
            3'd4: return z || (!z && !n);
            3'd5: return n || z;
            3'd6: return v;
            default: return 1'b1;
        endcase
    endfunction

    function automatic bit modelTaken(input logic [15:0] ins, input bit n, input bit z, input bit v);
        logic [3:0] op;
        op = ins[15:12];
        return (op == 4'hC || op == 4'hD) && modelCond(ins[11:9], n, z, v);
    endfunction

    function automatic logic [15:0] mkB(input logic [2:0] ccc, input logic [8:0] imm);
        return {4'hC, ccc, imm};
    endfunction

    function automatic logic [15:0] mkBR(input logic [2:0] ccc);
        return {4'hD, ccc, 9'h0A0};
    endfunction

    function automatic logic [15:0] mkSeq();
        logic [15:0] w;
        w = 16'($urandom);
        w[15:12] = 4'(w[15:12] % 12);
        return w;
    endfunction

    task automatic checkOutput(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Drive one cycle of inputs, compare all outputs against the model, then
    // advance the model across the clock edge.
    task automatic applyStimulus(input string tag, input logic [15:0] ins, input logic [15:0] rs,
                                 input bit st, input bit n, input bit z, input bit v, input bit r);
        bit t;
        int imm;
        instr   = ins;
        rs_data = rs;
        stall   = st;
        n_flag  = n;
        z_flag  = z;
        v_flag  = v;
        rst     = r;
        #2;
        t = modelTaken(ins, n, z, v);
        checkOutput({tag, ".pc_out"}, pc_out, 16'(modelPc));
        checkOutput({tag, ".pc_plus2"}, pc_plus2, 16'((modelPc + 2) & 32'hFFFF));
        checkOutput({tag, ".taken"}, {15'd0, taken}, {15'd0, t});
        checkOutput({tag, ".halted"}, {15'd0, halted}, {15'd0, modelHalted});
        checkOutput({tag, ".taken_cnt"}, 16'(taken_cnt), 16'(modelCnt));
        if (r) begin
            modelPc     = 0;
            modelHalted = 1'b0;
            modelCnt    = 0;
        end else if (!modelHalted && !st) begin
            if (t && modelCnt < CNT_MAX) modelCnt++;
            if (ins[15:12] == 4'hF) begin
                modelHalted = 1'b1;
            end else if (t && ins[15:12] == 4'hC) begin
                imm = int'(ins[8:0]);
                if (imm >= 256) imm = imm - 512;
                modelPc = (modelPc + 2 + imm * 2) & 32'hFFFF;
            end else if (t) begin
                modelPc = int'(rs);
            end else begin
                modelPc = (modelPc + 2) & 32'hFFFF;
            end
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [15:0] ins;
        logic [15:0] rs;
        bit st;
        bit r;

        rst = 1'b1; instr = 16'h0000; rs_data = 16'h0000; stall = 1'b0;
        n_flag = 1'b0; z_flag = 1'b0; v_flag = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        modelPc = 0; modelHalted = 1'b0; modelCnt = 0;

        // Reset state and straight-line fetch.
        for (int i = 0; i < 4; i++) applyStimulus("seq", mkSeq(), 16'($urandom), 0, 0, 0, 0, 0);

        // B EQ back by 4 halfwords from 0x0010, taken then not taken.
        applyStimulus("br_to10", mkBR(3'd7), 16'h0010, 0, 0, 0, 0, 0);
        applyStimulus("b_eq_taken", mkB(3'd1, 9'h1FC), 16'h0000, 0, 0, 1, 0, 0);
        applyStimulus("check_0a", mkSeq(), 16'h0000, 0, 0, 0, 0, 0);
        applyStimulus("br_to10b", mkBR(3'd7), 16'h0010, 0, 0, 0, 0, 0);
        applyStimulus("b_eq_not", mkB(3'd1, 9'h1FC), 16'h0000, 0, 0, 0, 0, 0);

        // BR OV with V clear then set.
        applyStimulus("br_ov_v0", mkBR(3'd6), 16'h1234, 0, 0, 0, 0, 0);
        applyStimulus("br_ov_v1", mkBR(3'd6), 16'h1234, 0, 0, 0, 1, 0);

        // Full ccc x NZV sweep, alternating B and BR.
        for (int c = 0; c < 8; c++) begin
            for (int f = 0; f < 8; f++) begin
                rs = 16'($urandom) & 16'hFFFE;
                ins = (f % 2 == 0) ? mkB(3'(c), 9'($urandom)) : mkBR(3'(c));
                applyStimulus("sweep", ins, rs, 0, f[2], f[1], f[0], 0);
            end
        end

        // Wrap at the top of memory, then PCS.
        applyStimulus("br_fffe", mkBR(3'd7), 16'hFFFE, 0, 0, 0, 0, 0);
        applyStimulus("wrap", mkSeq(), 16'h0000, 0, 0, 0, 0, 0);
        applyStimulus("br_40", mkBR(3'd7), 16'h0040, 0, 0, 0, 0, 0);
        applyStimulus("pcs", 16'hE123, 16'h0000, 0, 0, 0, 0, 0);
        applyStimulus("after_pcs", mkSeq(), 16'h0000, 0, 0, 0, 0, 0);

        // Odd BR target is taken verbatim.
        applyStimulus("br_odd", mkBR(3'd7), 16'h3331, 0, 0, 0, 0, 0);

        // Stalled HLT, then halt, then branches ignored, then reset.
        applyStimulus("br_20", mkBR(3'd7), 16'h0020, 0, 0, 0, 0, 0);
        applyStimulus("hlt_stall1", 16'hF000, 16'h0000, 1, 0, 0, 0, 0);
        applyStimulus("hlt_stall2", 16'hF000, 16'h0000, 1, 0, 0, 0, 0);
        applyStimulus("hlt_go", 16'hF000, 16'h0000, 0, 0, 0, 0, 0);
        for (int i = 0; i < 6; i++) begin
            st = 1'($urandom_range(0, 1));
            applyStimulus("halted_br", mkBR(3'd7), 16'($urandom), st, 0, 0, 0, 0);
        end
        applyStimulus("halt_rst", mkB(3'd7, 9'h010), 16'h0000, 0, 0, 0, 0, 1);
        applyStimulus("post_rst", mkSeq(), 16'h0000, 0, 0, 0, 0, 0);

        // Random mix of every opcode, stalls and occasional resets.
        for (int i = 0; i < 300; i++) begin
            case ($urandom_range(0, 5))
                0, 1:    ins = mkB(3'($urandom), 9'($urandom));
                2:       ins = mkBR(3'($urandom));
                3:       ins = 16'hE000 | 16'($urandom_range(0, 4095));
                4:       ins = ($urandom_range(0, 7) == 0) ? 16'hF000 : mkSeq();
                default: ins = mkSeq();
            endcase
            st = ($urandom_range(0, 3) == 0);
            r  = ($urandom_range(0, 15) == 0);
            applyStimulus("random", ins, 16'($urandom), st, 1'($urandom_range(0, 1)),
                          1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), r);
        end

        // Drive the taken counter into saturation and hold it there.
        applyStimulus("sat_rst", mkSeq(), 16'h0000, 0, 0, 0, 0, 1);
        for (int i = 0; i < CNT_MAX + 4; i++) begin
            applyStimulus("sat", mkBR(3'd7), 16'($urandom) & 16'hFFFE, 0, 0, 0, 0, 0);
        end
        applyStimulus("sat_hold", mkB(3'd7, 9'h004), 16'h0000, 0, 0, 0, 0, 0);
        applyStimulus("rst_with_b", mkB(3'd7, 9'h004), 16'h0000, 0, 0, 0, 0, 1);
        applyStimulus("after_rst_b", mkSeq(), 16'h0000, 0, 0, 0, 0, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
